bicubic_tap_mac: RTL



---
 rtl/bicubic_tap_mac.sv | 121 ++++++++++++
 1 files changed

// File: rtl/bicubic_tap_mac.sv
// Vertical bicubic tap MAC: 4-stage valid/ready pipeline forming a 4-row weighted
// sum per channel, then round, normalise and clamp to 8 bits. Optional macro: BICUBIC_OVF_CNT_EN.
module bicubic_tap_mac #(
   parameter int WW    = 17,
   parameter int WFRAC = 14,
   parameter int CH    = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [WW-1:0] w0,
   input  logic signed [WW-1:0] w1,
   input  logic signed [WW-1:0] w2,
   input  logic signed [WW-1:0] w3,
   input  logic [8*CH-1:0]      p0,
   input  logic [8*CH-1:0]      p1,
   input  logic [8*CH-1:0]      p2,
   input  logic [8*CH-1:0]      p3,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [8*CH-1:0]      pix_out,
   output logic [15:0]          ovf_cnt
);

   localparam int PW = WW + 9;
   localparam int SW = PW + 1;
   localparam int TW = PW + 2;
   localparam int QW = TW - WFRAC;
   localparam logic signed [TW-1:0] RND = TW'(2 ** (WFRAC - 1));

   // Valid/ready: a stage advances only when en=1, and en = !out_valid || out_ready,
   // so the whole pipe (bubbles included) freezes while a result waits downstream.
   logic            en;
   logic            v1, v2, v3, v4;
   logic [CH-1:0]   clamp;
   logic [8*CH-1:0] pix_next;

   assign en        = !v4 || out_ready;
   assign in_ready  = en;
   assign out_valid = v4;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
         v4 <= 1'b0;
      end else if (en) begin
         v1 <= in_valid;
         v2 <= v1;
         v3 <= v2;
         v4 <= v3;
      end
   end

   for (genvar k = 0; k < CH; k++) begin : g_ch
      logic signed [PW-1:0] prod0, prod1, prod2, prod3;
      logic signed [SW-1:0] s01, s23;
      logic signed [TW-1:0] total;
      logic signed [QW-1:0] q;
      logic                 unused_round;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            prod0 <= '0;
            prod1 <= '0;
            prod2 <= '0;
            prod3 <= '0;
            s01   <= '0;
            s23   <= '0;
            total <= '0;
         end else if (en) begin
            prod0 <= PW'($signed({1'b0, p0[8*k +: 8]})) * PW'(w0);
            prod1 <= PW'($signed({1'b0, p1[8*k +: 8]})) * PW'(w1);
            prod2 <= PW'($signed({1'b0, p2[8*k +: 8]})) * PW'(w2);
            prod3 <= PW'($signed({1'b0, p3[8*k +: 8]})) * PW'(w3);
            s01   <= SW'(prod0) + SW'(prod1);
            s23   <= SW'(prod2) + SW'(prod3);
            total <= TW'(s01) + TW'(s23) + RND;
         end
      end

      // Taking the upper bits of the sign-carrying total is the arithmetic shift.
      assign q                   = total[TW-1:WFRAC];
      assign unused_round        = ^total[WFRAC-1:0];
      assign clamp[k]            = q[QW-1] || (|q[QW-2:8]);
      assign pix_next[8*k +: 8]  = q[QW-1] ? 8'h00 : ((|q[QW-2:8]) ? 8'hFF : q[7:0]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pix_out <= '0;
      else if (en)
         pix_out <= pix_next;
   end

`ifdef BICUBIC_OVF_CNT_EN
   logic [16:0] ovf_sum;

   always_comb begin
      ovf_sum = {1'b0, ovf_cnt};
      for (int i = 0; i < CH; i++)
         ovf_sum = ovf_sum + 17'(clamp[i]);
   end

   // Saturating count; only a valid beat entering S4 contributes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ovf_cnt <= '0;
      else if (en && v3)
         ovf_cnt <= ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
   end
`else
   logic unused_clamp;

   assign unused_clamp = ^clamp;
   assign ovf_cnt      = '0;
`endif

endmodule
